serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 130 +++++++++++++
 tb/tb_serial_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx
//  Description : Parallel-to-serial transmitter. Accepts a WIDTH-bit word on
//                a valid/ready handshake and shifts it out MSB first, one bit
//                every DIV clocks, with a sample strobe for the downstream
//                serial-in register and a one-cycle done pulse per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             sdo,
    output logic             bit_stb,
    output logic             busy,
    output logic             done
);

    // Bit counter must reach WIDTH without wrapping; divider must hold DIV-1.
    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam int c_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_CNT_W-1:0] r_bitcnt;
    logic [c_DIV_W-1:0] r_div;

    logic w_ready;
    logic w_accept;
    logic w_strobe;
    logic w_last_bit;

    // Handshake qualifiers: ready is forced low while reset is asserted so a
    // word presented together with reset is never taken.
    assign w_ready    = (r_state == c_IDLE) && !rst;
    assign w_accept   = valid && w_ready;
    assign w_strobe   = (r_state == c_SHIFT) && (r_div == c_DIV_LAST);
    assign w_last_bit = (r_bitcnt == c_BIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: leave SHIFT on the strobe of the final bit
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_next = c_SHIFT;
                end
            end
            c_SHIFT: begin
                if (w_strobe && w_last_bit) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Shift register, bit counter and bit-period divider
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_div    <= '0;
        end else if (w_accept) begin
            r_shreg  <= data;
            r_bitcnt <= '0;
            r_div    <= '0;
        end else if (r_state == c_SHIFT) begin
            if (w_strobe) begin
                r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
                r_bitcnt <= r_bitcnt + c_CNT_W'(1);
                r_div    <= '0;
            end else begin
                r_div    <= r_div + c_DIV_W'(1);
            end
        end
    end

    // Outputs decoded from the current state; sdo is held low outside SHIFT
    always_comb begin
        ready   = w_ready;
        sdo     = 1'b0;
        bit_stb = w_strobe;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            c_SHIFT: begin
                sdo  = r_shreg[WIDTH-1];
                busy = 1'b1;
            end
            c_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx
//  Description : Self-checking bench for serial_tx. Two instances (DIV=4 and
//                DIV=1) are driven with directed and random words; every
//                cycle of a frame is compared against a timing model derived
//                from the frame rules (cycle index arithmetic), and a
//                serial-in register rebuilds each word from sdo/bit_stb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data0, data1;
    logic         valid0, valid1;
    logic         ready0, sdo0, stb0, busy0, done0;
    logic         ready1, sdo1, stb1, busy1, done1;
    logic [W-1:0] sipo0 = '0;
    logic [W-1:0] sipo1 = '0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(W), .DIV(D)) u_dut0 (
        .clk(clk), .rst(rst), .data(data0), .valid(valid0),
        .ready(ready0), .sdo(sdo0), .bit_stb(stb0), .busy(busy0), .done(done0)
    );

    serial_tx #(.WIDTH(W), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .data(data1), .valid(valid1),
        .ready(ready1), .sdo(sdo1), .bit_stb(stb1), .busy(busy1), .done(done1)
    );

    // Downstream serial-in registers: shift sdo in on every strobe
    always @(posedge clk) begin
        if (stb0) sipo0 <= {sipo0[W-2:0], sdo0};
        if (stb1) sipo1 <= {sipo1[W-2:0], sdo1};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int s, input logic v, input logic [W-1:0] d);
        if (s == 0) begin
            valid0 = v;
            data0  = d;
        end else begin
            valid1 = v;
            data1  = d;
        end
    endtask

    // Observed outputs packed as {ready, sdo, bit_stb, busy, done}
    function automatic logic [4:0] obs_vec(input int s);
        if (s == 0) return {ready0, sdo0, stb0, busy0, done0};
        return {ready1, sdo1, stb1, busy1, done1};
    endfunction

    // Expected outputs c cycles after the handshake edge for a frame of word
    // at d clocks per bit: bit i is on the line during cycles i*d+1..(i+1)*d
    // and is sampled in the last of them; then one done cycle, then idle.
    function automatic logic [4:0] model(input logic [W-1:0] word, input int d, input int c);
        int last;
        last = W * d;
        if (c >= 1 && c <= last)
            return {1'b0, word[W - 1 - (c - 1) / d], (c % d) == 0, 1'b1, 1'b0};
        if (c == last + 1)
            return 5'b00011;
        return 5'b10000;
    endfunction

    // Called in the handshake cycle with valid/data already presented. Returns
    // positioned in the first idle cycle after DONE (the next handshake cycle
    // when hold is set). meddle changes data and pulses valid mid-frame.
    task automatic run_frame(input int s, input logic [W-1:0] word, input bit hold,
                             input logic [W-1:0] next_word, input bit meddle);
        int d;
        int last;
        int rdy_low;
        logic [4:0] o;
        d       = (s == 0) ? D : 1;
        last    = W * d;
        rdy_low = 0;
        check($sformatf("hs_ready s%0d w%0h", s, word), obs_vec(s)[4], 1'b1);
        for (int c = 1; c <= last + 2; c++) begin
            tick();
            if (c == 1) begin
                if (hold) set_in(s, 1'b1, next_word);
                else      set_in(s, 1'b0, word);
            end
            if (meddle && c == 3) set_in(s, 1'b1, '0);
            if (meddle && c == 4) set_in(s, 1'b0, '0);
            o = obs_vec(s);
            check($sformatf("s%0d w%0h cyc%0d", s, word, c), o, model(word, d, c));
            if (o[4] == 1'b0) rdy_low++;
            if (c == last + 1)
                check($sformatf("sipo s%0d w%0h", s, word), (s == 0) ? sipo0 : sipo1, word);
        end
        check($sformatf("ready_low s%0d w%0h", s, word), rdy_low, last + 1);
    endtask

    initial begin
        logic [W-1:0] rw;
        rst = 1'b1;
        set_in(0, 1'b0, '0);
        set_in(1, 1'b0, '0);
        tick();
        tick();
        check("reset_held0", obs_vec(0), 5'b00000);
        check("reset_held1", obs_vec(1), 5'b00000);
        rst = 1'b0;
        #1;
        check("reset_rel0", obs_vec(0), 5'b10000);
        check("reset_rel1", obs_vec(1), 5'b10000);

        // 0xA5 at DIV=4
        set_in(0, 1'b1, 8'hA5);
        run_frame(0, 8'hA5, 1'b0, '0, 1'b0);

        // 0x81 at DIV=1, rebuilt by the serial-in register
        set_in(1, 1'b1, 8'h81);
        run_frame(1, 8'h81, 1'b0, '0, 1'b0);

        // Random words on both rates
        for (int i = 0; i < 3; i++) begin
            rw = W'($urandom);
            set_in(0, 1'b1, rw);
            run_frame(0, rw, 1'b0, '0, 1'b0);
            rw = W'($urandom);
            set_in(1, 1'b1, rw);
            run_frame(1, rw, 1'b0, '0, 1'b0);
        end

        // Back-to-back frames with valid held high across DONE
        set_in(0, 1'b1, 8'h3C);
        run_frame(0, 8'h3C, 1'b1, 8'hC3, 1'b0);
        run_frame(0, 8'hC3, 1'b0, '0, 1'b0);

        // Data change and stray valid pulse during a frame
        set_in(0, 1'b1, 8'hF0);
        run_frame(0, 8'hF0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("no_extra_frame %0d", i), obs_vec(0), 5'b10000);
        end

        // Reset asserted in cycle 13 of a 0xFF frame
        set_in(0, 1'b1, 8'hFF);
        tick();
        set_in(0, 1'b0, 8'hFF);
        for (int c = 2; c <= 13; c++) tick();
        check("pre_reset_busy", obs_vec(0)[1], 1'b1);
        rst = 1'b1;
        tick();
        check("abort_outputs", obs_vec(0), 5'b00000);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abort_no_done %0d", i), obs_vec(0), 5'b10000);
            tick();
        end
        set_in(0, 1'b1, 8'h01);
        run_frame(0, 8'h01, 1'b0, '0, 1'b0);

        // Reset coincident with valid must not accept the word
        rst = 1'b1;
        set_in(0, 1'b1, 8'h55);
        #1;
        check("rst_valid_ready", obs_vec(0)[4], 1'b0);
        tick();
        rst = 1'b0;
        set_in(0, 1'b0, 8'h55);
        #1;
        check("rst_valid_idle", obs_vec(0), 5'b10000);
        tick();
        check("rst_valid_noframe", obs_vec(0), 5'b10000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
